// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default frame parameters and a
// width helper. Used by the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } uart_state_e;

  localparam int DEF_DBIT    = 8;
  localparam int DEF_SB_TICK = 16;

  // Width of the tick counter. Four bits cover a full bit period. Stop bits
  // longer than one bit (SB_TICK of 24 or 32) need a wider counter.
  function automatic int tick_cnt_width(input int sb_tick);
    return (sb_tick > 16) ? $clog2(sb_tick) : 4;
  endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DBIT data bits sent LSB first, then a stop bit
// of SB_TICK oversampling ticks. Timing comes from an external s_tick that
// pulses 16 times per bit period.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DBIT    = DEF_DBIT,
  parameter int SB_TICK = DEF_SB_TICK
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic       s_tick,
  input  logic [7:0] din,
  output logic       tx_done_tick,
  output logic       tx_busy,
  output logic       tx
);

  localparam int SW = tick_cnt_width(SB_TICK);

  localparam logic [SW-1:0] BIT_LAST  = SW'(15);
  localparam logic [SW-1:0] STOP_LAST = SW'(SB_TICK - 1);
  localparam logic [2:0]    N_LAST    = 3'(DBIT - 1);

  uart_state_e   state_reg, state_next;
  logic [SW-1:0] s_reg, s_next;
  logic [2:0]    n_reg, n_next;
  logic [7:0]    b_reg, b_next;
  logic          tx_reg, tx_next;

  // State register: all frame state plus the line flop.
  // NOTE: every register here is reset, including the shift register, so an
  // aborted frame leaves no stale data behind.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      s_reg     <= '0;
      n_reg     <= '0;
      b_reg     <= '0;
      tx_reg    <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments, so every register updates from the
      // values it had before the edge.
      state_reg <= state_next;
      s_reg     <= s_next;
      n_reg     <= n_next;
      b_reg     <= b_next;
      tx_reg    <= tx_next;
    end
  end

  // Next-state logic: advances only on s_tick, except for accepting a request.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a value unassigned and no latch is inferred.
    state_next   = state_reg;
    s_next       = s_reg;
    n_next       = n_reg;
    b_next       = b_reg;
    tx_next      = tx_reg;
    tx_done_tick = 1'b0;

    case (state_reg)
      IDLE: begin
        tx_next = 1'b1;
        if (tx_start) begin
          state_next = START;
          s_next     = '0;
          b_next     = din;
          tx_next    = 1'b0;
        end
      end

      START: begin
        if (s_tick) begin
          if (s_reg == BIT_LAST) begin
            state_next = DATA;
            s_next     = '0;
            n_next     = '0;
            tx_next    = b_reg[0];
          end else begin
            s_next = s_reg + SW'(1);
          end
        end
      end

      DATA: begin
        if (s_tick) begin
          if (s_reg == BIT_LAST) begin
            s_next = '0;
            b_next = {1'b0, b_reg[7:1]};
            if (n_reg == N_LAST) begin
              state_next = STOP;
              tx_next    = 1'b1;
            end else begin
              n_next  = n_reg + 3'd1;
              // b_reg[1] becomes b[0] after this shift.
              tx_next = b_reg[1];
            end
          end else begin
            s_next = s_reg + SW'(1);
          end
        end
      end

      STOP: begin
        if (s_tick) begin
          if (s_reg == STOP_LAST) begin
            // The done pulse is raised while still in STOP, so a tx_start in
            // this same cycle is ignored and the earliest restart is next clk.
            state_next   = IDLE;
            tx_done_tick = 1'b1;
          end else begin
            s_next = s_reg + SW'(1);
          end
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign tx_busy = (state_reg != IDLE);
  assign tx      = tx_reg;

endmodule
